// File: rtl/uart_rx_sched.sv
// Round-robin arbiter and sequencer that hands the UART matrix receiver to one requester at a time.
// Optional BUSY watchdog with receiver abort is enabled by defining UART_SCHED_WDOG_EN.
module uart_rx_sched #(
  parameter int unsigned ARM_TIMEOUT  = 4096,
  parameter int unsigned BUSY_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [3:0] req_action0,
  input  logic       req_row0,
  input  logic [1:0] req_col0,
  input  logic [3:0] req_action1,
  input  logic       req_row1,
  input  logic [1:0] req_col1,
  input  logic       rx_busy,
  output logic [3:0] action,
  output logic       row,
  output logic [1:0] col,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       rx_abort
);

  localparam int unsigned MaxTimeout = (ARM_TIMEOUT > BUSY_TIMEOUT) ? ARM_TIMEOUT : BUSY_TIMEOUT;
  localparam int unsigned CntW       = (MaxTimeout > 2) ? $clog2(MaxTimeout) : 1;
  localparam logic [CntW-1:0] ArmLast = CntW'(ARM_TIMEOUT - 1);
`ifdef UART_SCHED_WDOG_EN
  localparam logic [CntW-1:0] BusyLast = CntW'(BUSY_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {StIdle, StArm, StBusy, StFin} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;  // 1: requester 1 has priority on a tie
  logic            own_q, own_d;  // index of the requester being served
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      act_q, act_d;
  logic            row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            abort_q, abort_d;

  logic [1:0] pend;
  logic       win;
  logic [3:0] win_act;
  logic       win_row;
  logic [1:0] win_col;
  logic       win_valid;

  always_comb begin
    // A requester still holding req while its done/err is visible is not a new request.
    pend      = req & ~(done_q | err_q);
    win       = pend[1] & (~pend[0] | ptr_q);
    win_act   = win ? req_action1 : req_action0;
    win_row   = win ? req_row1 : req_row0;
    win_col   = win ? req_col1 : req_col0;
    win_valid = (win_act >= 4'd2) && (win_act <= 4'd5);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    row_d   = row_q;
    col_d   = col_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    abort_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_busy && (pend != 2'b00)) begin
          ptr_d = ~win;
          if (win_valid) begin
            gnt_d   = {win, ~win};
            act_d   = win_act;
            row_d   = win_row;
            col_d   = win_col;
            own_d   = win;
            cnt_d   = '0;
            state_d = StArm;
          end else begin
            err_d = {win, ~win};
          end
        end
      end
      StArm: begin
        if (rx_busy) begin
          cnt_d   = '0;
          state_d = StBusy;
        end else if (cnt_q == ArmLast) begin
          err_d   = {own_q, ~own_q};
          gnt_d   = '0;
          act_d   = '0;
          row_d   = 1'b0;
          col_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBusy: begin
        if (!rx_busy) begin
          state_d = StFin;
`ifdef UART_SCHED_WDOG_EN
        end else if (cnt_q == BusyLast) begin
          abort_d = 1'b1;
          err_d   = {own_q, ~own_q};
          gnt_d   = '0;
          act_d   = '0;
          row_d   = 1'b0;
          col_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StFin: begin
        done_d  = {own_q, ~own_q};
        gnt_d   = '0;
        act_d   = '0;
        row_d   = 1'b0;
        col_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      act_q   <= '0;
      row_q   <= 1'b0;
      col_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      row_q   <= row_d;
      col_q   <= col_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign action   = act_q;
  assign row      = row_q;
  assign col      = col_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rx_abort = abort_q;

endmodule

// File: tb/tb_uart_rx_sched.sv
// Bench for uart_rx_sched: vector table of single-requester transfers, then hand-written
// contention, timeout, busy-at-idle, reset and watchdog sequences with an event scoreboard.
module tb_uart_rx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] req_action0, req_action1;
  logic       req_row0, req_row1;
  logic [1:0] req_col0, req_col1;
  logic       rx_busy;
  logic [3:0] action;
  logic       row;
  logic [1:0] col, gnt, done, err;
  logic       rx_abort;

  always #5 clk = ~clk;

  uart_rx_sched #(
    .ARM_TIMEOUT (16),
    .BUSY_TIMEOUT(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_action0(req_action0),
    .req_row0   (req_row0),
    .req_col0   (req_col0),
    .req_action1(req_action1),
    .req_row1   (req_row1),
    .req_col1   (req_col1),
    .rx_busy    (rx_busy),
    .action     (action),
    .row        (row),
    .col        (col),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rx_abort   (rx_abort)
  );

  typedef struct {
    logic [1:0] done;
    logic [1:0] err;
    logic       abort;
  } evt_t;

  typedef struct {
    int unsigned who;
    logic [3:0]  act;
    logic        rw;
    logic [1:0]  cl;
    int unsigned dly;
    int unsigned len;
    bit          drop;
    bit          valid;
  } vec_t;

  evt_t        sb[$];
  vec_t        vecs[9];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_evt(input logic [1:0] d, input logic [1:0] e, input logic a);
    evt_t ev;
    ev.done  = d;
    ev.err   = e;
    ev.abort = a;
    sb.push_back(ev);
  endtask

  // Advance one cycle, sample after the edge, and retire any completion event.
  task automatic tick();
    evt_t ev;
    logic ok;
    @(posedge clk);
    #1;
    ok = $onehot0(gnt) && $onehot0(done) && $onehot0(err) && ((done & err) == 2'b00);
    check("invariants", {31'd0, ok}, 32'd1);
    if ((done != 2'b00) || (err != 2'b00) || (rx_abort != 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {27'd0, rx_abort, err, done}, 32'd0);
      end else begin
        ev = sb.pop_front();
        check("sb_event", {27'd0, rx_abort, err, done}, {27'd0, ev.abort, ev.err, ev.done});
      end
    end
  endtask

  task automatic set_req(input int unsigned who, input logic [3:0] a, input logic r,
                         input logic [1:0] c);
    if (who == 1) begin
      req_action1 = a;
      req_row1    = r;
      req_col1    = c;
      req[1]      = 1'b1;
    end else begin
      req_action0 = a;
      req_row0    = r;
      req_col0    = c;
      req[0]      = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.who == 1) ? 2'b10 : 2'b01;
    set_req(v.who, v.act, v.rw, v.cl);
    if (v.valid) begin
      push_evt(oh, 2'b00, 1'b0);
      tick();
      check("gnt", {30'd0, gnt}, {30'd0, oh});
      check("fields", {25'd0, action, row, col}, {25'd0, v.act, v.rw, v.cl});
      // Scramble the requester's fields: the granted command must not follow them.
      if (v.who == 1) begin
        req_action1 = ~v.act; req_row1 = ~v.rw; req_col1 = ~v.cl;
      end else begin
        req_action0 = ~v.act; req_row0 = ~v.rw; req_col0 = ~v.cl;
      end
      for (int k = 0; k < int'(v.dly); k++) begin
        tick();
        check("arm_hold", {23'd0, gnt, action, row, col}, {23'd0, oh, v.act, v.rw, v.cl});
      end
      rx_busy = 1'b1;
      for (int k = 0; k < int'(v.len); k++) begin
        tick();
        check("busy_hold", {23'd0, gnt, action, row, col}, {23'd0, oh, v.act, v.rw, v.cl});
        if (v.drop && k == 0) req[v.who] = 1'b0;
      end
      rx_busy = 1'b0;
      tick();
      check("fin_no_done", {28'd0, gnt, done}, {28'd0, oh, 2'b00});
      tick();
      check("done_lat", {30'd0, done}, {30'd0, oh});
      check("fin_clear", {23'd0, gnt, action, row, col}, 32'd0);
      req[v.who] = 1'b0;
      tick();
    end else begin
      push_evt(2'b00, oh, 1'b0);
      tick();
      check("err", {30'd0, err}, {30'd0, oh});
      check("err_no_gnt", {26'd0, gnt, action}, 32'd0);
      req[v.who] = 1'b0;
      tick();
      check("err_after", {26'd0, gnt, action}, 32'd0);
    end
  endtask

  task automatic finish_xfer(input string name, input logic [1:0] oh);
    rx_busy = 1'b1;
    repeat (3) tick();
    rx_busy = 1'b0;
    tick();
    tick();
    check(name, {30'd0, done}, {30'd0, oh});
  endtask

  initial begin
    vecs[0] = '{0, 4'd2, 1'b1, 2'd3, 5, 40, 1'b0, 1'b1};
    vecs[1] = '{1, 4'd3, 1'b0, 2'd2, 0, 3, 1'b0, 1'b1};
    vecs[2] = '{0, 4'd4, 1'b1, 2'd0, 2, 1, 1'b1, 1'b1};
    vecs[3] = '{1, 4'd5, 1'b1, 2'd1, 7, 10, 1'b1, 1'b1};
    vecs[4] = '{1, 4'd7, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{0, 4'd0, 1'b1, 2'd1, 0, 0, 1'b0, 1'b0};
    vecs[6] = '{0, 4'd1, 1'b0, 2'd2, 0, 0, 1'b0, 1'b0};
    vecs[7] = '{1, 4'd6, 1'b1, 2'd3, 0, 0, 1'b0, 1'b0};
    vecs[8] = '{0, 4'd15, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0};

    rst = 1'b1; req = '0; rx_busy = 1'b0;
    req_action0 = '0; req_row0 = 1'b0; req_col0 = '0;
    req_action1 = '0; req_row1 = 1'b0; req_col1 = '0;
    repeat (2) tick();
    check("reset_outs", {20'd0, action, row, col, gnt, done, err, rx_abort}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention from reset: 0 first, then 1, then 0 on re-request, then a tie favouring 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 4'd5, 1'b0, 2'd1);
    set_req(1, 4'd5, 1'b1, 2'd2);
    push_evt(2'b01, 2'b00, 1'b0);
    tick();
    check("rr_first", {29'd0, gnt, row}, {29'd0, 2'b01, 1'b0});
    finish_xfer("rr_first_done", 2'b01);
    check("rr_gap", {30'd0, gnt}, 32'd0);
    req[0] = 1'b0;
    push_evt(2'b10, 2'b00, 1'b0);
    tick();
    check("rr_second", {27'd0, gnt, row, col}, {27'd0, 2'b10, 1'b1, 2'd2});
    tick();
    set_req(0, 4'd5, 1'b0, 2'd1);
    push_evt(2'b01, 2'b00, 1'b0);
    finish_xfer("rr_second_done", 2'b10);
    req[1] = 1'b0;
    tick();
    check("rr_third", {30'd0, gnt}, {30'd0, 2'b01});
    finish_xfer("rr_third_done", 2'b01);
    req[0] = 1'b0;
    tick();
    set_req(0, 4'd2, 1'b0, 2'd0);
    set_req(1, 4'd3, 1'b1, 2'd3);
    push_evt(2'b10, 2'b00, 1'b0);
    tick();
    check("rr_tie_ptr1", {26'd0, gnt, action}, {26'd0, 2'b10, 4'd3});
    push_evt(2'b01, 2'b00, 1'b0);
    finish_xfer("rr_tie_done1", 2'b10);
    req[1] = 1'b0;
    tick();
    check("rr_tie_next0", {26'd0, gnt, action}, {26'd0, 2'b01, 4'd2});
    finish_xfer("rr_tie_done0", 2'b01);
    req[0] = 1'b0;
    tick();

    // ARM timeout: gnt held for 16 cycles, err on the 17th, then grantable again.
    set_req(0, 4'd3, 1'b1, 2'd1);
    push_evt(2'b00, 2'b01, 1'b0);
    tick();
    check("arm_gnt", {30'd0, gnt}, {30'd0, 2'b01});
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("arm_wait", {28'd0, gnt, err}, {28'd0, 2'b01, 2'b00});
    end
    tick();
    check("arm_timeout", {24'd0, gnt, err, action}, {24'd0, 2'b00, 2'b01, 4'd0});
    req[0] = 1'b0;
    tick();
    set_req(0, 4'd2, 1'b0, 2'd0);
    push_evt(2'b01, 2'b00, 1'b0);
    tick();
    check("arm_regrant", {30'd0, gnt}, {30'd0, 2'b01});
    finish_xfer("arm_regrant_done", 2'b01);
    req[0] = 1'b0;
    tick();

    // Stray busy in IDLE blocks the grant; then reset mid-BUSY drops everything silently.
    rx_busy = 1'b1;
    set_req(1, 4'd4, 1'b1, 2'd2);
    repeat (3) begin
      tick();
      check("busy_idle_nognt", {30'd0, gnt}, 32'd0);
    end
    rx_busy = 1'b0;
    tick();
    check("busy_idle_gnt", {30'd0, gnt}, {30'd0, 2'b10});
    rx_busy = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {20'd0, action, row, col, gnt, done, err, rx_abort}, 32'd0);
    rst = 1'b0; req = '0; rx_busy = 1'b0;
    repeat (4) begin
      tick();
      check("rst_no_done", {28'd0, done, err}, 32'd0);
    end

`ifdef UART_SCHED_WDOG_EN
    set_req(0, 4'd5, 1'b0, 2'd3);
    push_evt(2'b00, 2'b01, 1'b1);
    tick();
    check("wdog_gnt", {30'd0, gnt}, {30'd0, 2'b01});
    rx_busy = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      tick();
      check("wdog_wait", {29'd0, rx_abort, gnt}, {29'd0, 1'b0, 2'b01});
    end
    tick();
    check("wdog_abort", {24'd0, rx_abort, err, gnt, action[2:0]},
          {24'd0, 1'b1, 2'b01, 2'b00, 3'd0});
    rx_busy = 1'b0;
    req[0] = 1'b0;
    tick();
`else
    set_req(1, 4'd5, 1'b0, 2'd3);
    push_evt(2'b10, 2'b00, 1'b0);
    tick();
    rx_busy = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      check("busy_no_wdog", {29'd0, rx_abort, gnt}, {29'd0, 1'b0, 2'b10});
    end
    rx_busy = 1'b0;
    tick();
    tick();
    check("busy_no_wdog_done", {30'd0, done}, {30'd0, 2'b10});
    req[1] = 1'b0;
    tick();
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sched.md
Name: uart_rx_sched

Overview:
Arbitration and sequencing controller for the UART matrix receiver.
- Two requesters (host, local) each post a receive command (cell/row/column/all) against the 2x4 matrix.
- The block grants one requester at a time (round-robin) and drives the receiver's action/row/col inputs for the duration of one transfer.
- It tracks the receiver's busy flag to detect transfer start and end, and reports done/err back to the granted requester.

Parameters:
ARM_TIMEOUT, 4096, clock cycles to wait in ARM for rx_busy to rise before aborting with err.
BUSY_TIMEOUT, 65536, max cycles in BUSY before watchdog abort (used only with UART_SCHED_WDOG_EN).

Ports:
clk  input  1  system clock
rst  input  1  reset
req  input  2  per-requester request level; bit i belongs to requester i
req_action0  input  4  requester 0 command: 2 cell, 3 row, 4 column, 5 all
req_row0  input  1  requester 0 row
req_col0  input  2  requester 0 column
req_action1  input  4  requester 1 command
req_row1  input  1  requester 1 row
req_col1  input  2  requester 1 column
rx_busy  input  1  receiver busy flag
action  output  4  to receiver; 0 = no-op
row  output  1  to receiver
col  output  2  to receiver
gnt  output  2  one-hot grant; held for the whole transfer
done  output  2  1-cycle completion pulse, per requester
err  output  2  1-cycle error pulse, per requester
rx_abort  output  1  1-cycle receiver abort pulse (only with UART_SCHED_WDOG_EN; else tied 0)

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: action=0, row=0, col=0, gnt=0, done=0, err=0, rx_abort=0, state=IDLE, round-robin pointer favours requester 0, timeout counter=0.
- States: IDLE, ARM, BUSY, FIN.
- IDLE, general:
  - Evaluates only when rx_busy=0.
  - If rx_busy=1 (stray traffic), no grant is issued; requests wait.
- IDLE, arbitration:
  - The winner is the pending requester with priority per the round-robin pointer.
  - The pointer moves to the other requester after every grant or rejection.
  - With a single requester pending, that requester wins regardless of the pointer.
- IDLE, valid command (action in 2..5):
  - Next cycle: gnt[i]=1 and action/row/col are loaded from the winner's fields.
  - Fields are sampled once and held internally; later changes on req_* are ignored.
  - State goes to ARM and the timeout counter clears.
- IDLE, invalid command (action not in 2..5):
  - Next cycle: err[i]=1 for one cycle, no gnt, state stays IDLE, pointer advances.
- ARM:
  - action/row/col are held stable.
  - If rx_busy is sampled 1, go to BUSY next cycle.
  - Otherwise the counter increments. When the counter reaches ARM_TIMEOUT-1 with rx_busy still 0, next cycle: err[i]=1, gnt=0, action=0, state IDLE.
- BUSY:
  - action/row/col remain driven. The receiver latches them only at the start bit, but holding them keeps the interface deterministic.
  - When rx_busy is sampled 0, go to FIN.
- FIN (one cycle): done[i]=1, gnt=0, action=0, row=0, col=0; then IDLE.
- Throughput: the earliest next grant is the cycle after FIN, giving a 1-cycle minimum gap between transfers.
- Latency:
  - req to gnt: 1 cycle.
  - rx_busy fall to done: 2 cycles (BUSY to FIN, FIN registered output).
- Requester protocol: req is level. A requester holds req until it sees done or err, then must deassert for at least 1 cycle before re-requesting.
- Request dropped mid-transfer: ignored. The transfer completes and done is still pulsed.
- Simultaneous requests in IDLE: exactly one grant. The other requester is served next if still pending.
- Reset mid-transfer: all outputs return to reset values on the next edge. No done/err is issued for the aborted transfer.
- Invariants:
  - gnt, done and err are each at most one-hot.
  - done and err are never both asserted for the same requester in the same cycle.

Optional Feature:
UART_SCHED_WDOG_EN:
- When defined: in BUSY, a counter runs. If rx_busy remains 1 for BUSY_TIMEOUT cycles, next cycle: rx_abort=1 for one cycle, err[i]=1, gnt=0, action=0, state IDLE.
- When undefined: BUSY waits indefinitely, rx_abort is tied 0, and the BUSY_TIMEOUT parameter is unused.

Test Plan:
- Single request: req=01, action0=2, row0=1, col0=3; rx_busy rises 5 cycles after gnt, falls 40 cycles later -> gnt=01 one cycle after req; action=2, row=1, col=3 held until FIN; done=01 exactly 2 cycles after rx_busy falls.
- Contention: req=11 from reset, both action=5 -> requester 0 granted first, done; then requester 1 granted; then on re-request requester 0 wins again.
- Invalid command: req=10, action1=7 -> err=10 one cycle later, gnt never asserted, action stays 0.
- ARM timeout: ARM_TIMEOUT=16, valid request, rx_busy held 0 -> err pulses on the 17th cycle after gnt and gnt drops; the next request is grantable.
- Busy at idle and reset: rx_busy=1 before req -> no gnt until rx_busy=0. Separately, rst asserted mid-BUSY -> all outputs 0 next cycle, no done.
- Watchdog (UART_SCHED_WDOG_EN, BUSY_TIMEOUT=32): rx_busy stuck 1 -> rx_abort and err pulse together after 32 BUSY cycles, state returns to IDLE.
